// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine.
// Combinational content only; no latency.
// No flow control here; consumers own the handshakes.
package ex_muldiv_unit_pkg;

  localparam logic [3:0] FUNCT_MUL = 4'b0100;
  localparam logic [3:0] FUNCT_DIV = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; zero latency.
// No backpressure; the caller decides when to register the result.
module ex_muldiv_unit_step #(
  parameter int WIDTH = 16
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   shl;

  // MUL: acc = {partial, multiplier}, add multiplicand on LSB then shift right.
  // DIV: acc = {remainder, dividend/quotient}, shift left then trial-subtract.
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    shl   = {acc_i[2*WIDTH-2:0], 1'b0};
    trial = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, opnd_i};
    if (is_div_i) begin
      if (trial[WIDTH]) begin
        acc_o = shl;
      end else begin
        acc_o = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle signed MUL/DIV engine for the EX stage; lo -> Rd, hi -> R15.
// Latency WIDTH+2 cycles from start to done (1 cycle for divide-by-zero).
// Stalls IF/ID and ID/EX while busy; flush aborts and drops stall immediately.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [3:0]       funct_code,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_a_q;
  logic [WIDTH-1:0]     result_lo_q;
  logic [WIDTH-1:0]     result_hi_q;
  logic                 dbz_q;

  logic                 op_valid;
  logic                 op_is_div;
  logic                 accept;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_lo;
  logic [WIDTH-1:0]     fix_hi;

  assign op_is_div = (funct_code == FUNCT_DIV);
  assign op_valid  = (funct_code == FUNCT_MUL) || op_is_div;
  assign accept    = (state_q == ST_IDLE) && start && op_valid;
  assign abs_a     = RD1[WIDTH-1] ? -RD1 : RD1;
  assign abs_b     = RD2[WIDTH-1] ? -RD2 : RD2;

  ex_muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // Sign correction of the magnitude result; remainder follows the dividend.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    if (is_div_q) begin
      fix_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Stall covers the accept cycle plus RUN and FIX; flush kills both strobes.
  assign stall       = !flush && (accept || (state_q == ST_RUN) || (state_q == ST_FIX));
  assign done        = !flush && (state_q == ST_DONE);
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = dbz_q;

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_a_q     <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      dbz_q       <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            is_div_q  <= op_is_div;
            neg_res_q <= RD1[WIDTH-1] ^ RD2[WIDTH-1];
            neg_a_q   <= RD1[WIDTH-1];
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            if (op_is_div) begin
              opnd_q <= abs_b;
              acc_q  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd_q <= abs_a;
              acc_q  <= {{WIDTH{1'b0}}, abs_b};
            end
            if (op_is_div && (RD2 == '0)) begin
              result_lo_q <= '1;
              result_hi_q <= RD1;
              dbz_q       <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_lo_q <= fix_lo;
          result_hi_q <= fix_hi;
          state_q     <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, start;
  logic [3:0]  funct_code;
  logic [15:0] RD1, RD2;
  logic        stall, done, div_by_zero;
  logic [15:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  fc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] last_lo, last_hi;
  logic        last_dbz;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .start       (start),
    .funct_code  (funct_code),
    .RD1         (RD1),
    .RD2         (RD2),
    .stall       (stall),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one instruction held in ID/EX until done (or until a planned flush/reset).
  task automatic run_op(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] elo, input logic [15:0] ehi, input logic edbz,
                        input int flush_at, input int reset_at);
    bit   valid, dz, got_done, aborted;
    int   lat;
    exp_t e;
    valid    = (fc == FUNCT_MUL) || (fc == FUNCT_DIV);
    dz       = (fc == FUNCT_DIV) && (b == 16'h0);
    lat      = dz ? 1 : 18;
    got_done = 0;
    aborted  = (flush_at >= 0) || (reset_at >= 0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = 1'b1; funct_code = fc; RD1 = a; RD2 = b;
      flush = (c == flush_at);
      reset = (c == reset_at);
      if (c == 0 && valid && !aborted) begin
        e.lo = elo; e.hi = ehi; e.dbz = edbz;
        sb_q.push_back(e);
      end
      @(negedge clk);
      if (c == reset_at) break;
      if (c == flush_at) begin
        chk("flush_stall", {31'b0, stall}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        break;
      end
      if (!valid) begin
        chk("bad_funct_stall", {31'b0, stall}, 32'd0);
        chk("bad_funct_done", {31'b0, done}, 32'd0);
        if (c == 3) break;
        continue;
      end
      chk($sformatf("stall_c%0d", c), {31'b0, stall}, {31'b0, (c < lat)});
      chk($sformatf("done_c%0d", c), {31'b0, done}, {31'b0, (c == lat)});
      if (done) begin
        got_done = 1;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result_lo", {16'b0, result_lo}, {16'b0, e.lo});
          chk("result_hi", {16'b0, result_hi}, {16'b0, e.hi});
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          last_lo = e.lo; last_hi = e.hi; last_dbz = e.dbz;
        end
        break;
      end
    end
    if (valid && !aborted && !got_done) chk("timeout_no_done", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{FUNCT_MUL, 16'd7,    16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0};
    vecs[1] = '{FUNCT_MUL, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
    vecs[2] = '{FUNCT_DIV, 16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0};
    vecs[3] = '{FUNCT_DIV, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0};
    vecs[4] = '{FUNCT_DIV, 16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1};
    vecs[5] = '{FUNCT_MUL, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0};
    vecs[6] = '{FUNCT_MUL, 16'hFFFF, 16'd1,    16'hFFFF, 16'hFFFF, 1'b0};
    vecs[7] = '{FUNCT_DIV, 16'd7,    16'd100,  16'h0000, 16'h0007, 1'b0};
    vecs[8] = '{FUNCT_DIV, 16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1};
    vecs[9] = '{FUNCT_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};

    reset = 1'b1; flush = 1'b0; start = 1'b0;
    funct_code = 4'h0; RD1 = '0; RD2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_lo", {16'b0, result_lo}, 32'd0);
    chk("rst_hi", {16'b0, result_hi}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    // Table vectors applied back-to-back: each start lands in the IDLE after DONE.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].fc, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dbz, -1, -1);
    end
    go_idle();

    // Unsupported funct code must not stall or complete; results must hold.
    run_op(4'b0011, 16'd9, 16'd9, 16'h0, 16'h0, 1'b0, -1, -1);
    go_idle();
    @(negedge clk);
    chk("hold_lo", {16'b0, result_lo}, {16'b0, last_lo});
    chk("hold_hi", {16'b0, result_hi}, {16'b0, last_hi});

    // Flush at cycle 8 of MUL 3*4, then rerun it from IDLE.
    run_op(FUNCT_MUL, 16'd3, 16'd4, 16'h0, 16'h0, 1'b0, 8, -1);
    go_idle();
    @(negedge clk);
    chk("post_flush_stall", {31'b0, stall}, 32'd0);
    chk("post_flush_done", {31'b0, done}, 32'd0);
    chk("post_flush_lo", {16'b0, result_lo}, {16'b0, last_lo});
    chk("post_flush_hi", {16'b0, result_hi}, {16'b0, last_hi});
    chk("post_flush_dbz", {31'b0, div_by_zero}, {31'b0, last_dbz});
    run_op(FUNCT_MUL, 16'd3, 16'd4, 16'h000C, 16'h0000, 1'b0, -1, -1);

    // Divide-by-zero result first so the reset clearly wipes non-zero outputs.
    run_op(FUNCT_DIV, 16'd5, 16'd0, 16'hFFFF, 16'h0005, 1'b1, -1, -1);
    run_op(FUNCT_DIV, 16'd1000, 16'd3, 16'h0, 16'h0, 1'b0, -1, 10);
    go_idle();
    @(negedge clk);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_lo", {16'b0, result_lo}, 32'd0);
    chk("mid_rst_hi", {16'b0, result_hi}, 32'd0);
    chk("mid_rst_dbz", {31'b0, div_by_zero}, 32'd0);
    run_op(FUNCT_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, -1, -1);
    go_idle();

    repeat (3) @(negedge clk);
    chk("idle_no_done", {31'b0, done}, 32'd0);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
